// File: rtl/rx_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_writer_if
// Purpose  : Bundles the signals between the MAC RX byte stream, the frame
//            writer and the FIFO write port.
//   master : drives the RX byte stream and the synchronised read pointer,
//            observes the FIFO write-port and status outputs.
//   slave  : the frame writer side.
//   Stream  : rx_data, rx_valid, rx_last, rx_error
//   Pointer : rd_address (already in the data_in_clock domain)
//   FIFO    : fifo_data, fifo_enable, fifo_reset, fifo_reset_address
//   Status  : commit_address, frame_committed, frame_length, frames_dropped
// Revision : 1.0 - initial release
// ============================================================================
interface rx_frame_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 12
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_last;
  logic                  rx_error;
  logic [FIFO_DEPTH-1:0] rd_address;

  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_enable;
  logic                  fifo_reset;
  logic [FIFO_DEPTH-1:0] fifo_reset_address;
  logic [FIFO_DEPTH-1:0] commit_address;
  logic                  frame_committed;
  logic [15:0]           frame_length;
  logic [15:0]           frames_dropped;

  modport master (
    output rx_data, rx_valid, rx_last, rx_error, rd_address,
    input  fifo_data, fifo_enable, fifo_reset, fifo_reset_address,
    input  commit_address, frame_committed, frame_length, frames_dropped
  );

  modport slave (
    input  rx_data, rx_valid, rx_last, rx_error, rd_address,
    output fifo_data, fifo_enable, fifo_reset, fifo_reset_address,
    output commit_address, frame_committed, frame_length, frames_dropped
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_writer
// Purpose  : Streams received frame bytes into the write port of the
//            dual-clock frame FIFO. Good frames are committed by advancing
//            commit_address. Bad, runt, oversize or overflowing frames are
//            discarded by rewinding the FIFO write pointer to the last commit.
// Ports    :
//   data_in_clock : write-domain clock
//   reset         : asynchronous, active-high reset
//   bus (slave)   : RX stream in, rd_address in; FIFO write port and
//                   commit/length/drop status out (all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_writer #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 12,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  wire logic        data_in_clock,
  input  wire logic        reset,
  rx_frame_writer_if.slave bus
);

  localparam logic [FIFO_DEPTH-1:0] c_addr_one = FIFO_DEPTH'(1);
  localparam logic [15:0]           c_min_len  = 16'(MIN_FRAME_LEN);
  localparam logic [15:0]           c_max_len  = 16'(MAX_FRAME_LEN);
  localparam logic [15:0]           c_len_sat  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                r_state;
  logic [FIFO_DEPTH-1:0] r_wr_ptr;
  logic [15:0]           r_len;
  logic                  r_bad;

  logic [DATA_WIDTH-1:0] r_fifo_data;
  logic                  r_fifo_enable;
  logic                  r_fifo_reset;
  logic [FIFO_DEPTH-1:0] r_fifo_reset_address;
  logic [FIFO_DEPTH-1:0] r_commit_address;
  logic                  r_frame_committed;
  logic [15:0]           r_frame_length;
  logic [15:0]           r_frames_dropped;

  logic [FIFO_DEPTH-1:0] w_wr_next;
  logic                  w_full;
  logic [15:0]           w_len_cur;
  logic                  w_bad_cur;
  logic                  w_can_write;
  logic                  w_good_end;

  // One slot is always kept empty so that full and empty stay distinguishable
  // for the read side.
  assign w_wr_next = r_wr_ptr + c_addr_one;
  assign w_full    = (w_wr_next == bus.rd_address);

  // Length and error status including the byte sampled this cycle. A byte
  // arriving in IDLE starts a fresh frame, so old state is ignored there.
  assign w_len_cur = (r_state == ST_IDLE) ? 16'd1
                   : ((r_len == c_len_sat) ? r_len : r_len + 16'd1);
  assign w_bad_cur = ((r_state == ST_IDLE) ? 1'b0 : r_bad) | bus.rx_error;

  assign w_can_write = !w_full && (w_len_cur <= c_max_len);

  // A frame commits only if its last byte actually lands in the FIFO.
  assign w_good_end = !w_bad_cur && w_can_write &&
                      (w_len_cur >= c_min_len) && (w_len_cur <= c_max_len);

  always_ff @(posedge data_in_clock or posedge reset) begin
    if (reset) begin
      r_state              <= ST_IDLE;
      r_wr_ptr             <= '0;
      r_len                <= '0;
      r_bad                <= 1'b0;
      r_fifo_data          <= '0;
      r_fifo_enable        <= 1'b0;
      r_fifo_reset         <= 1'b0;
      r_fifo_reset_address <= '0;
      r_commit_address     <= '0;
      r_frame_committed    <= 1'b0;
      r_frame_length       <= '0;
      r_frames_dropped     <= '0;
    end else begin
      // Pulse outputs default low; a write and a rewind are mutually
      // exclusive paths below, so enable and reset never overlap.
      r_fifo_enable     <= 1'b0;
      r_fifo_reset      <= 1'b0;
      r_frame_committed <= 1'b0;

      case (r_state)
        ST_IDLE, ST_RECV: begin
          if (bus.rx_valid) begin
            r_len <= w_len_cur;
            r_bad <= w_bad_cur;
            if (bus.rx_last) begin
              r_state <= ST_IDLE;
              if (w_good_end) begin
                r_fifo_enable     <= 1'b1;
                r_fifo_data       <= bus.rx_data;
                r_wr_ptr          <= w_wr_next;
                r_commit_address  <= w_wr_next;
                r_frame_length    <= w_len_cur;
                r_frame_committed <= 1'b1;
              end else begin
                r_fifo_reset         <= 1'b1;
                r_fifo_reset_address <= r_commit_address;
                r_wr_ptr             <= r_commit_address;
                if (r_frames_dropped != c_len_sat)
                  r_frames_dropped <= r_frames_dropped + 16'd1;
              end
            end else if (w_can_write) begin
              r_fifo_enable <= 1'b1;
              r_fifo_data   <= bus.rx_data;
              r_wr_ptr      <= w_wr_next;
              r_state       <= ST_RECV;
            end else begin
              // FIFO full or frame too long: stop writing and wait for the
              // end of the frame to rewind.
              r_bad   <= 1'b1;
              r_state <= ST_DROP;
            end
          end
        end

        ST_DROP: begin
          if (bus.rx_valid && bus.rx_last) begin
            r_state              <= ST_IDLE;
            r_fifo_reset         <= 1'b1;
            r_fifo_reset_address <= r_commit_address;
            r_wr_ptr             <= r_commit_address;
            if (r_frames_dropped != c_len_sat)
              r_frames_dropped <= r_frames_dropped + 16'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_data          = r_fifo_data;
  assign bus.fifo_enable        = r_fifo_enable;
  assign bus.fifo_reset         = r_fifo_reset;
  assign bus.fifo_reset_address = r_fifo_reset_address;
  assign bus.commit_address     = r_commit_address;
  assign bus.frame_committed    = r_frame_committed;
  assign bus.frame_length       = r_frame_length;
  assign bus.frames_dropped     = r_frames_dropped;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_writer
// Purpose  : Self-checking bench for rx_frame_writer. Instance A (12-bit
//            FIFO address) is compared every cycle against a frame-level
//            model; instance B (6-bit FIFO address) covers FIFO overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_frame_writer;

  localparam int NA      = 4096;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rx_frame_writer_if #(.DATA_WIDTH(8), .FIFO_DEPTH(12)) bus_a ();
  rx_frame_writer_if #(.DATA_WIDTH(8), .FIFO_DEPTH(6))  bus_b ();

  rx_frame_writer #(
    .DATA_WIDTH(8), .FIFO_DEPTH(12), .MIN_FRAME_LEN(MIN_LEN), .MAX_FRAME_LEN(MAX_LEN)
  ) dut_a (
    .data_in_clock(clk), .reset(reset), .bus(bus_a)
  );

  rx_frame_writer #(
    .DATA_WIDTH(8), .FIFO_DEPTH(6), .MIN_FRAME_LEN(MIN_LEN), .MAX_FRAME_LEN(MAX_LEN)
  ) dut_b (
    .data_in_clock(clk), .reset(reset), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model of instance A ----------------
  int m_wr, m_commit, m_len;
  bit m_in_frame, m_dropping, m_bad;
  bit e_en, e_rst, e_cmt;
  int e_data, e_rst_addr, e_commit, e_len, e_drop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wr = 0; m_commit = 0; m_len = 0;
      m_in_frame = 0; m_dropping = 0; m_bad = 0;
      e_en = 0; e_rst = 0; e_cmt = 0;
      e_data = 0; e_rst_addr = 0; e_commit = 0; e_len = 0; e_drop = 0;
    end else begin
      bit full, can;
      e_en = 0; e_rst = 0; e_cmt = 0;
      if (bus_a.rx_valid) begin
        if (!m_in_frame) begin
          m_len = 1; m_bad = bus_a.rx_error; m_dropping = 0;
        end else begin
          m_len = (m_len < 65535) ? m_len + 1 : 65535;
          m_bad = m_bad | bus_a.rx_error;
        end
        full = (((m_wr + 1) % NA) == int'(bus_a.rd_address));
        can  = !m_dropping && !full && (m_len <= MAX_LEN);
        if (bus_a.rx_last) begin
          if (!m_bad && can && m_len >= MIN_LEN && m_len <= MAX_LEN) begin
            e_en = 1; e_data = int'(bus_a.rx_data);
            m_wr = (m_wr + 1) % NA; m_commit = m_wr;
            e_commit = m_commit; e_cmt = 1; e_len = m_len;
          end else begin
            e_rst = 1; e_rst_addr = m_commit; m_wr = m_commit;
            if (e_drop < 65535) e_drop++;
          end
          m_in_frame = 0;
        end else begin
          m_in_frame = 1;
          if (can) begin
            e_en = 1; e_data = int'(bus_a.rx_data); m_wr = (m_wr + 1) % NA;
          end else if (!m_dropping) begin
            m_bad = 1; m_dropping = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and observation counters ----------------
  int a_writes, a_commits, a_resets, a_last_rst_addr;
  int b_writes, b_resets, b_last_rst_addr;

  always @(posedge clk) begin
    #1;
    chk("a_fifo_enable", bus_a.fifo_enable, e_en);
    chk("a_fifo_reset", bus_a.fifo_reset, e_rst);
    chk("a_frame_committed", bus_a.frame_committed, e_cmt);
    chk("a_commit_address", bus_a.commit_address, e_commit);
    chk("a_frame_length", bus_a.frame_length, e_len);
    chk("a_frames_dropped", bus_a.frames_dropped, e_drop);
    if (e_en) chk("a_fifo_data", bus_a.fifo_data, e_data);
    if (e_rst) chk("a_fifo_reset_address", bus_a.fifo_reset_address, e_rst_addr);
    if (bus_a.fifo_enable) a_writes++;
    if (bus_a.frame_committed) a_commits++;
    if (bus_a.fifo_reset) begin a_resets++; a_last_rst_addr = int'(bus_a.fifo_reset_address); end
    if (bus_b.fifo_enable && bus_b.fifo_reset) chk("b_enable_reset_overlap", 1, 0);
    if (bus_b.fifo_enable) b_writes++;
    if (bus_b.fifo_reset) begin b_resets++; b_last_rst_addr = int'(bus_b.fifo_reset_address); end
  end

  // ---------------- stimulus ----------------
  task automatic send_a(input int n, input int err_at, input bit with_last, input int seed);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      bus_a.rx_valid = 1'b1;
      bus_a.rx_data  = 8'(seed + i * 7);
      bus_a.rx_error = (i == err_at);
      bus_a.rx_last  = with_last && (i == n);
    end
  endtask

  task automatic idle_a(input int cycles);
    @(negedge clk);
    bus_a.rx_valid = 1'b0; bus_a.rx_last = 1'b0; bus_a.rx_error = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic clear_counts();
    a_writes = 0; a_commits = 0; a_resets = 0; a_last_rst_addr = -1;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.rx_valid = 0; bus_a.rx_last = 0; bus_a.rx_error = 0; bus_a.rx_data = 0; bus_a.rd_address = 0;
    bus_b.rx_valid = 0; bus_b.rx_last = 0; bus_b.rx_error = 0; bus_b.rx_data = 0; bus_b.rd_address = 0;
    clear_counts();
    b_writes = 0; b_resets = 0; b_last_rst_addr = -1;
    repeat (3) @(negedge clk);
    chk("reset_commit_address", bus_a.commit_address, 0);
    chk("reset_fifo_enable", bus_a.fifo_enable, 0);
    chk("reset_fifo_reset_address", bus_a.fifo_reset_address, 0);
    chk("reset_frames_dropped", bus_a.frames_dropped, 0);
    reset = 1'b0;
    idle_a(2);

    // Good 64-byte frame: 64 writes, commit at 64.
    clear_counts();
    send_a(64, 0, 1, 16); idle_a(3);
    chk("good_writes", a_writes, 64);
    chk("good_commits", a_commits, 1);
    chk("good_commit_address", bus_a.commit_address, 64);
    chk("good_frame_length", bus_a.frame_length, 64);

    // Error on byte 50 of 100: 99 writes, rewind to 64.
    clear_counts();
    send_a(100, 50, 1, 3); idle_a(3);
    chk("err_writes", a_writes, 99);
    chk("err_resets", a_resets, 1);
    chk("err_reset_address", a_last_rst_addr, 64);
    chk("err_dropped", bus_a.frames_dropped, 1);
    chk("err_commit_address", bus_a.commit_address, 64);

    // Runt: 10 bytes, dropped.
    clear_counts();
    send_a(10, 0, 1, 99); idle_a(3);
    chk("runt_writes", a_writes, 9);
    chk("runt_reset_address", a_last_rst_addr, 64);
    chk("runt_dropped", bus_a.frames_dropped, 2);

    // Maximum-length frame commits.
    clear_counts();
    send_a(1518, 0, 1, 5); idle_a(3);
    chk("max_writes", a_writes, 1518);
    chk("max_commit_address", bus_a.commit_address, 1582);
    chk("max_frame_length", bus_a.frame_length, 1518);

    // One byte over maximum: writes stop at 1518, rewind.
    clear_counts();
    send_a(1519, 0, 1, 8); idle_a(3);
    chk("over_writes", a_writes, 1518);
    chk("over_reset_address", a_last_rst_addr, 1582);
    chk("over_dropped", bus_a.frames_dropped, 3);
    chk("over_commit_address", bus_a.commit_address, 1582);

    // Reset mid-frame: outputs clear immediately, no rewind pulse.
    clear_counts();
    send_a(30, 0, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_commit_address", bus_a.commit_address, 0);
    chk("midrst_frames_dropped", bus_a.frames_dropped, 0);
    chk("midrst_frame_length", bus_a.frame_length, 0);
    chk("midrst_fifo_enable", bus_a.fifo_enable, 0);
    bus_a.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle_a(2);
    chk("midrst_resets", a_resets, 0);

    // Two zero-gap good frames from address 0.
    clear_counts();
    send_a(64, 0, 1, 40);
    send_a(64, 0, 1, 80);
    idle_a(3);
    chk("b2b_commits", a_commits, 2);
    chk("b2b_writes", a_writes, 128);
    chk("b2b_commit_address", bus_a.commit_address, 128);

    // Advance commit to 4000, then wrap with read pointer at 4000.
    send_a(1518, 0, 1, 2); idle_a(1);
    send_a(1518, 0, 1, 3); idle_a(1);
    send_a(836, 0, 1, 4);  idle_a(3);
    chk("prewrap_commit_address", bus_a.commit_address, 4000);
    bus_a.rd_address = 12'd4000;
    clear_counts();
    send_a(200, 0, 1, 77); idle_a(3);
    chk("wrap_writes", a_writes, 200);
    chk("wrap_commit_address", bus_a.commit_address, 104);
    chk("wrap_frame_length", bus_a.frame_length, 200);

    // Overflow on the 64-entry instance: 63 writes then rewind to 0.
    b_writes = 0; b_resets = 0; b_last_rst_addr = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      bus_b.rx_valid = 1'b1;
      bus_b.rx_data  = 8'(i);
      bus_b.rx_last  = (i == 80);
    end
    @(negedge clk);
    bus_b.rx_valid = 1'b0; bus_b.rx_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_writes", b_writes, 63);
    chk("ovf_resets", b_resets, 1);
    chk("ovf_reset_address", b_last_rst_addr, 0);
    chk("ovf_dropped", bus_b.frames_dropped, 1);
    chk("ovf_commit_address", bus_b.commit_address, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_frame_writer.md
# rx_frame_writer

Receive-side frame writer between the MAC RX byte stream and the write port of the dual-clock frame `fifo`. It streams each frame's bytes into the FIFO and tracks a committed-frame boundary. Good frames are committed by advancing `commit_address`. Bad, runt, oversize or overflowing frames are discarded by rewinding the FIFO write pointer to the last commit through `data_in_reset`/`data_in_reset_address`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width; equals FIFO `DATA_IN_WIDTH`.
- `FIFO_DEPTH`, 12, FIFO address width; the FIFO holds 2^FIFO_DEPTH entries.
- `MIN_FRAME_LEN`, 64, shortest accepted frame, in bytes.
- `MAX_FRAME_LEN`, 1518, longest accepted frame, in bytes.

Ports:
- `data_in_clock`  in  1  write-domain clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  DATA_WIDTH  received byte.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_last`  in  1  qualified by `rx_valid`; marks the final byte of a frame.
- `rx_error`  in  1  qualified by `rx_valid`; PHY/CRC error; sticky for the current frame.
- `rd_address`  in  FIFO_DEPTH  FIFO read pointer, already synchronised into `data_in_clock`.
- `fifo_data`  out  DATA_WIDTH  to FIFO `data_in`.
- `fifo_enable`  out  1  to FIFO `data_in_enable`.
- `fifo_reset`  out  1  to FIFO `data_in_reset`.
- `fifo_reset_address`  out  FIFO_DEPTH  to FIFO `data_in_reset_address`.
- `commit_address`  out  FIFO_DEPTH  address one past the last byte of the last good frame.
- `frame_committed`  out  1  one-cycle pulse when a frame is committed.
- `frame_length`  out  16  byte count of the last committed frame.
- `frames_dropped`  out  16  count of discarded frames; saturates at 0xFFFF.

## Operation
- Internal `wr_ptr` mirrors the FIFO write address. On a write it increments modulo 2^FIFO_DEPTH. On a rewind it loads `commit_address`.
- Full condition: `wr_ptr + 1 == rd_address` (modulo). One slot always stays empty.
- Internal `len` (16-bit, saturating) counts bytes of the current frame. Internal `bad` flag marks the current frame for discard.

State machine, with states IDLE, RECV, DROP:
- **IDLE**
  - On `rx_valid`: `len` = 1, `bad` = `rx_error`.
  - If not full, write the byte. If full, set `bad` and go to DROP.
  - If `rx_last` is also set, perform end-of-frame handling and stay in IDLE.
  - Otherwise go to RECV or DROP as above.
- **RECV**
  - Each `rx_valid` increments `len` and ORs `rx_error` into `bad`.
  - Bytes are written while not full and `len` ≤ MAX_FRAME_LEN.
  - If the FIFO is full or `len` would exceed MAX_FRAME_LEN: no write, set `bad`, go to DROP.
  - On `rx_last`: perform end-of-frame handling, go to IDLE.
- **DROP**
  - No writes.
  - On `rx_valid` && `rx_last`: perform end-of-frame handling as a bad frame, go to IDLE.

End-of-frame handling:
- The frame is good if `!bad`, the final byte was written, and MIN_FRAME_LEN ≤ `len` ≤ MAX_FRAME_LEN. Otherwise it is bad.
- Good frame:
  - The final byte is written.
  - `commit_address` ← `wr_ptr + 1`.
  - `frame_length` ← `len`.
  - `frame_committed` pulses.
- Bad frame:
  - The final byte is not written.
  - `fifo_reset` pulses with `fifo_reset_address` = `commit_address`.
  - `wr_ptr` ← `commit_address`.
  - `frames_dropped` increments, saturating at 0xFFFF.

## Timing
- All outputs are registered.
- A byte sampled at edge E appears on `fifo_data`/`fifo_enable` during the cycle after E; the FIFO captures it at E+1.
- End-of-frame sampled at E: `frame_committed` or `fifo_reset` is high for exactly the cycle after E, with `fifo_enable` low in the bad case.
- `fifo_reset` and `fifo_enable` are never high in the same cycle.
- Back-to-back frames with zero gap are supported. A new frame starts at the `commit_address`/`wr_ptr` updated at the previous end edge.
- `rd_address` may change every cycle; full is evaluated on the current sample.
- Reset values, all immediately on `reset`:
  - All outputs are 0.
  - `wr_ptr` = 0, state = IDLE.
  - Reset mid-frame discards the frame without a `fifo_reset` pulse; the FIFO is reset by the same `reset`.
- Address arithmetic wraps modulo 2^FIFO_DEPTH; lengths saturate at 0xFFFF.

## Test plan
- **Good frame:** from reset, send a 64-byte good frame. Expect 64 writes at addresses 0..63, `commit_address` = 64, one `frame_committed` pulse, `frame_length` = 64.
- **Error frame:** follow with a 100-byte frame with `rx_error` on byte 50. Expect 99 writes, a `fifo_reset` pulse with address 64, `frames_dropped` = 1, `commit_address` unchanged.
- **Runt:** send a 10-byte good-CRC frame. Expect rewind to the current commit and `frames_dropped` incremented. Then send a 1518-byte frame: it commits. Then send a 1519-byte frame: writes stop after byte 1518, the frame is rewound.
- **Overflow:** with `FIFO_DEPTH` = 6 and `rd_address` = 0, send an 80-byte frame. Expect exactly 63 writes, DROP until `rx_last`, rewind to 0.
- **Wrap:** with commit = `rd_address` = 4000, send a 200-byte good frame. Expect writes at 4000..4095 then 0..103, `commit_address` = 104.
- **Reset mid-frame / back-to-back:** assert `reset` after 30 bytes; expect all outputs 0 and the next frame starting at address 0. Then send two zero-gap good 64-byte frames; expect commits at 64 then 128.
